// File: rtl/booth_dec_acc.sv
// booth_dec_acc: radix-8 Booth digit decoder and serial accumulator.
// Accepts one encoded digit (neg + one-hot f0..f4) per beat, forms +/-k*A,
// shifts it by 3*digit_index and accumulates into a PW-bit signed product.
// Optional feature macro: BOOTH_DEC_ONEHOT_CHK_EN (malformed-digit check on err).
module booth_dec_acc #(
  parameter  int unsigned WA = 8,
  parameter  int unsigned ND = 3,
  localparam int unsigned PW = WA + 3 * ND
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [WA-1:0] a,
  input  logic          neg,
  input  logic          f0,
  input  logic          f1,
  input  logic          f2,
  input  logic          f3,
  input  logic          f4,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product,
  output logic          err
);

  localparam int unsigned MW = WA + 3;                  // partial-product magnitude width
  localparam int unsigned XW = PW - MW;                 // sign-extension bits to PW
  localparam int unsigned IW = $clog2(ND + 1);          // digit index width
  localparam int unsigned SW = $clog2(3 * ND + 1);      // shift amount width

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nx;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] w_acc_nx;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nx;
  logic [WA-1:0] r_a;
  logic [WA-1:0] w_a_nx;
  logic          r_flag;
  logic          w_flag_nx;
  logic          r_in_ready;
  logic          r_out_valid;

  logic          w_in_fire;
  logic          w_final;
  logic [IW-1:0] w_didx;
  logic [SW-1:0] w_shamt;
  logic [WA-1:0] w_x;
  logic [MW-1:0] w_x1;
  logic [MW-1:0] w_x2;
  logic [MW-1:0] w_x3;
  logic [MW-1:0] w_x4;
  logic [4:0]    w_sel;
  logic [MW-1:0] w_mag;
  logic          w_bad;
  logic [PW-1:0] w_pp_ext;
  logic [PW-1:0] w_pp;
  logic [PW-1:0] w_pp_sh;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_acc;
  assign err       = r_flag;

  assign w_in_fire = in_valid & r_in_ready;

  // Digit index of the current beat: 0 for the opening beat in IDLE
  assign w_didx  = (r_state == S_IDLE) ? '0 : r_idx;
  assign w_final = in_last | (w_didx == IW'(ND - 1));
  assign w_shamt = SW'({w_didx, 1'b0}) + SW'(w_didx);

  // Multiplicand for this beat: live input on the opening beat, latched copy after
  assign w_x  = (r_state == S_IDLE) ? a : r_a;
  assign w_x1 = {{3{w_x[WA-1]}}, w_x};
  assign w_x2 = {w_x1[MW-2:0], 1'b0};
  assign w_x4 = {w_x1[MW-3:0], 2'b00};
  assign w_x3 = w_x1 + w_x2;

  assign w_sel = {f4, f3, f2, f1, f0};

`ifdef BOOTH_DEC_ONEHOT_CHK_EN
  // Strict one-hot decode; anything else contributes 0 and flags the transaction
  always_comb begin
    w_mag = '0;
    w_bad = 1'b0;
    case (w_sel)
      5'b00001: w_mag = '0;
      5'b00010: w_mag = w_x1;
      5'b00100: w_mag = w_x2;
      5'b01000: w_mag = w_x3;
      5'b10000: w_mag = w_x4;
      default:  w_bad = 1'b1;
    endcase
  end
`else
  // Priority decode f4 > f3 > f2 > f1; f0 or no select yields 0
  always_comb begin
    w_mag = '0;
    w_bad = 1'b0;
    casez (w_sel)
      5'b1????: w_mag = w_x4;
      5'b01???: w_mag = w_x3;
      5'b001??: w_mag = w_x2;
      5'b0001?: w_mag = w_x1;
      default:  w_mag = '0;
    endcase
  end
`endif

  // Sign-extend, apply digit sign, then weight by 8^index
  assign w_pp_ext = {{XW{w_mag[MW-1]}}, w_mag};
  assign w_pp     = neg ? (~w_pp_ext + PW'(1)) : w_pp_ext;
  assign w_pp_sh  = w_pp << w_shamt;

  // Next-state and datapath update
  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_idx_nx   = r_idx;
    w_a_nx     = r_a;
    w_flag_nx  = r_flag;
    case (r_state)
      S_IDLE: begin
        if (w_in_fire && in_first) begin
          w_a_nx     = a;
          w_acc_nx   = w_pp_sh;
          w_idx_nx   = IW'(1);
          w_flag_nx  = w_bad;
          w_state_nx = w_final ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (w_in_fire) begin
          w_acc_nx  = r_acc + w_pp_sh;
          w_idx_nx  = r_idx + IW'(1);
          w_flag_nx = r_flag | w_bad;
          if (w_final) begin
            w_state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_idx       <= '0;
      r_a         <= '0;
      r_flag      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_acc       <= w_acc_nx;
      r_idx       <= w_idx_nx;
      r_a         <= w_a_nx;
      r_flag      <= w_flag_nx;
      r_in_ready  <= (w_state_nx != S_DONE);
      r_out_valid <= (w_state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_booth_dec_acc.sv
// Directed self-checking bench for booth_dec_acc (WA=8, ND=3, PW=17).
module tb_booth_dec_acc;

  localparam int unsigned WA = 8;
  localparam int unsigned ND = 3;
  localparam int unsigned PW = WA + 3 * ND;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_first;
  logic          in_last;
  logic [WA-1:0] a;
  logic          neg;
  logic          f0, f1, f2, f3, f4;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          err;

  int total = 0;
  int bad   = 0;

  booth_dec_acc #(.WA(WA), .ND(ND)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .a(a),
    .neg(neg), .f0(f0), .f1(f1), .f2(f2), .f3(f3), .f4(f4),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat with a raw select vector {f4,f3,f2,f1,f0}
  task automatic drive(input bit first, input bit last, input logic [7:0] av,
                       input bit n, input logic [4:0] sel);
    in_valid = 1'b1;
    in_first = first;
    in_last  = last;
    a        = av;
    neg      = n;
    {f4, f3, f2, f1, f0} = sel;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic dig(input bit first, input bit last, input logic [7:0] av,
                     input bit n, input int k);
    logic [4:0] sel;
    sel = 5'b00001 << k;
    drive(first, last, av, n, sel);
  endtask

  // Checks the DONE presentation, then completes the output handshake
  task automatic take_output(input string tag, input logic [PW-1:0] exp_p, input bit exp_e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in_ready"},  32'(in_ready),  32'd0);
    check({tag, ".product"},   32'(product),   32'(exp_p));
    check({tag, ".err"},       32'(err),       32'(exp_e));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".idle_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; a = '0;
    neg = 1'b0; {f4, f3, f2, f1, f0} = 5'b00001; out_ready = 1'b0;
    tick();
    tick();
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.product",   32'(product),   32'd0);
    check("rst.err",       32'(err),       32'd0);
    rst = 1'b0;
    tick();

    // A=5: -15 + 80 + 0 = 65, explicit last on digit 2
    dig(1, 0, 8'd5, 1, 3);
    check("t1.mid_valid", 32'(out_valid), 32'd0);
    check("t1.mid_ready", 32'(in_ready),  32'd1);
    dig(0, 0, 8'd5, 0, 2);
    dig(0, 1, 8'd5, 0, 0);
    take_output("t1", 17'h00041, 1'b0);

    // A=-7: -2*-7*64 = 896, terminated by digit index ND-1 without in_last
    dig(1, 0, 8'hF9, 0, 0);
    dig(0, 0, 8'hF9, 0, 0);
    dig(0, 0, 8'hF9, 1, 2);
    take_output("t2a", 17'h00380, 1'b0);

    // A=-128: 256*64 = 16384
    dig(1, 0, 8'h80, 0, 0);
    dig(0, 0, 8'h80, 0, 0);
    dig(0, 0, 8'h80, 1, 2);
    take_output("t2b", 17'h04000, 1'b0);

    // A=3, single digit +4 -> 12; hold with out_ready=0 while new beats are offered
    dig(1, 1, 8'd3, 0, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; a = 8'h11;
      neg = 1'b0; {f4, f3, f2, f1, f0} = 5'b00010;
      check("t3.hold_product", 32'(product),   32'd12);
      check("t3.hold_ready",   32'(in_ready),  32'd0);
      check("t3.hold_valid",   32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    take_output("t3", 17'd12, 1'b0);

    // Negative result: A=5, single digit -4 -> -20 mod 2^17
    dig(1, 1, 8'd5, 1, 4);
    take_output("neg4", 17'h1FFEC, 1'b0);

    // neg with f0 yields 0
    dig(1, 1, 8'd77, 1, 0);
    take_output("negzero", 17'd0, 1'b0);

    // Stray non-first beat in IDLE is dropped; gapped stream matches gap-free result
    dig(0, 0, 8'd5, 0, 4);
    check("t4.stray_valid", 32'(out_valid), 32'd0);
    check("t4.stray_ready", 32'(in_ready),  32'd1);
    dig(1, 0, 8'd5, 1, 3);
    tick();
    dig(0, 0, 8'd5, 0, 2);
    tick();
    dig(0, 1, 8'd5, 0, 0);
    take_output("t4", 17'h00041, 1'b0);

    // Reset after two digits abandons the transaction
    dig(1, 0, 8'd9, 0, 4);
    dig(0, 0, 8'd9, 1, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5.rst_valid",   32'(out_valid), 32'd0);
    check("t5.rst_ready",   32'(in_ready),  32'd1);
    check("t5.rst_product", 32'(product),   32'd0);
    tick();
    check("t5.no_output",   32'(out_valid), 32'd0);
    dig(1, 0, 8'd5, 1, 3);
    dig(0, 0, 8'd5, 0, 2);
    dig(0, 1, 8'd5, 0, 0);
    take_output("t5", 17'h00041, 1'b0);

    // Malformed digit 0 (f1=f2=1), then +2, 0
    drive(1, 0, 8'd5, 0, 5'b00110);
    dig(0, 0, 8'd5, 0, 2);
    dig(0, 1, 8'd5, 0, 0);
`ifdef BOOTH_DEC_ONEHOT_CHK_EN
    take_output("t6", 17'd80, 1'b1);
    dig(1, 0, 8'd5, 1, 3);
    dig(0, 0, 8'd5, 0, 2);
    dig(0, 1, 8'd5, 0, 0);
    take_output("t6.clean", 17'h00041, 1'b0);
`else
    // Priority decode takes f2: 10 + 80 = 90
    take_output("t6", 17'd90, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_dec_acc.md
# booth_dec_acc

Radix-8 Booth digit decoder and serial accumulator: the consumer end of the `booth_enc` digit interface in the R8ACC multiplier path. It accepts one encoded digit per handshake (`neg` plus one-hot magnitude select `f0`..`f4`, meaning 0..4) together with a signed multiplicand. Each digit is decoded into a partial product ±k·A, shifted by 3·digit-index, and accumulated. The signed product is presented on a valid/ready output port.

## Interface
- `WA`, 8: multiplicand width, signed two's complement.
- `ND`, 3: maximum digits per transaction (3 covers an 8-bit multiplier).
- `PW`, `WA+3*ND`: product width (derived; do not override).

Ports (clock and reset first):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  digit beat valid.
- `in_ready`  out  1  block accepts beat.
- `in_first`  in  1  beat is digit 0; `a` is sampled with this beat.
- `in_last`  in  1  final digit of the transaction.
- `a`  in  WA  multiplicand; used only on `in_first` beats.
- `neg`, `f0`, `f1`, `f2`, `f3`, `f4`  in  1 each  encoded digit: sign and one-hot magnitude 0/1/2/3/4.
- `out_valid`  out  1  product available.
- `out_ready`  in  1  downstream accepts product.
- `product`  out  PW  signed Σ dᵢ·A·8ⁱ.
- `err`  out  1  transaction saw a malformed digit. Tied 0 when the check is compiled out.

## Operation
- FSM states: IDLE, ACC, DONE.
- **IDLE**
  - `in_ready`=1.
  - Beats with `in_first`=0 are accepted and discarded.
  - Beat with `in_first`=1: latch `a` into A_r, set acc = pp(digit, `a`), set idx=1, clear the error flag.
  - If the beat is final, go to DONE; otherwise go to ACC.
- **ACC**
  - `in_ready`=1.
  - Each accepted beat: acc += pp(digit, A_r) << 3·idx, then idx++. `in_first` is ignored here.
  - Go to DONE when the beat is final.
- **Final beat:** `in_last`=1, or digit index ND-1, whichever comes first. A beat at index ND-1 terminates the transaction even with `in_last`=0.
- **DONE**
  - `in_ready`=0, `out_valid`=1, `product`=acc, both held stable.
  - On `out_ready`=1, go to IDLE.
- **pp(d, X)**
  - Magnitude k·X with k∈{0,1,2,3,4}.
  - 3X is formed as X+(X<<1), combinational; 2X and 4X are shifts.
  - Width WA+3, sign-extended to PW.
  - Negated (two's complement) when `neg`=1.
  - `neg` with `f0` yields 0.
- **Accumulation:** modulo 2^PW. For legal Booth digit streams the result is exact.
- **Early `in_last`:** digits not received are treated as 0.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `err`=0, acc=0, idx=0.
- Throughput: one digit per cycle while `in_ready`=1.
- Latency: final beat accepted at cycle T, then `out_valid`=1 at T+1.
- Back-to-back: `in_ready` is 0 while in DONE. The cycle after the output handshake, `in_ready`=1 again in IDLE.
- Minimum transaction: ND+1 cycles for ND digits (ND accepted beats plus 1 DONE cycle with `out_ready`=1).
- Output hold: `product` and `err` are stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-transaction: abandons the partial accumulation on the next edge and returns all state to reset values. No output is produced for the abandoned transaction.
- `in_valid` and `out_ready` are both sampled each cycle. An input beat is never accepted in the same cycle as an output handshake.

## Configuration
- Macro: `BOOTH_DEC_ONEHOT_CHK_EN`.
- **Defined**
  - A digit whose `f0`..`f4` is not exactly one-hot contributes 0 to the accumulation.
  - Such a digit sets a sticky flag, which appears on `err` together with `product`.
  - The flag clears on the next `in_first` accept or on reset.
- **Undefined**
  - No check is made; `err` is constant 0.
  - Magnitude uses priority f4>f3>f2>f1. `f0` is not decoded; no select high means 0.

## Test plan
- A=5; digits (neg,k) = (1,3),(0,2),(0,0), last on digit 2 -> after 3 beats, `out_valid` at the next cycle with `product`=17'h00041 (65), `err`=0.
- A=-7; digits (0,0),(0,0),(1,2) -> `product`=17'h00380 (896). A=-128 with the same digits -> 17'h04000 (16384).
- A=3; single digit (0,4) with `in_first`=`in_last`=1 -> DONE next cycle, `product`=12. Then hold `out_ready`=0 for 5 cycles -> `product` stable, `in_ready`=0; release -> IDLE.
- `in_valid` toggling 1,0,1,0,1 across a 3-digit stream, plus a stray non-first beat in IDLE -> the stray beat is dropped and the result equals the gap-free case.
- `rst`=1 after 2 digits -> next cycle IDLE, `out_valid`=0. A fresh A=5 transaction then yields 65.
- With `BOOTH_DEC_ONEHOT_CHK_EN`: A=5, digit0 with `f1`=`f2`=1, then (0,2),(0,0) -> `product`=80, `err`=1. The next clean transaction gives `err`=0.
